fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetch requests, pairs each returned word
// with its address in a small FIFO, and supports redirect (flush + PC reload).
module fetch_queue #(
    parameter int ADDRESS_BITS = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC = {ADDRESS_BITS{1'b0}}
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      next_PC_select,
    input  logic [ADDRESS_BITS-1:0]   target_PC,
    output logic                      req_valid,
    output logic [ADDRESS_BITS-1:0]   req_addr,
    input  logic                      rsp_valid,
    input  logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [DATA_WIDTH-1:0]     inst_data,
    output logic [ADDRESS_BITS-1:0]   inst_PC,
    output logic [ADDRESS_BITS-1:0]   PC,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]        DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]        PTR_ONE    = PTR_W'(1);
    localparam logic [ADDRESS_BITS-1:0] PC_STEP    = ADDRESS_BITS'(4);
    localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~(ADDRESS_BITS'(3));

    logic [ADDRESS_BITS-1:0] pc_r;
    logic [CNT_W-1:0]        count_r;
    logic                    inflight_r;
    logic [ADDRESS_BITS-1:0] inflight_addr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [ADDRESS_BITS-1:0] pc_mem_r   [DEPTH];
    logic [DATA_WIDTH-1:0]   data_mem_r [DEPTH];

    logic [CNT_W-1:0]        occupancy_s;
    logic                    issue_s;
    logic                    push_s;
    logic                    pop_s;
    logic [CNT_W-1:0]        count_next_s;
    logic [ADDRESS_BITS-1:0] pc_next_s;
    logic [PTR_W-1:0]        rd_ptr_next_s;
    logic [PTR_W-1:0]        wr_ptr_next_s;

    // Handshake decode and next-state for PC, occupancy and pointers.
    always_comb begin
        occupancy_s   = count_r + {{PTR_W{1'b0}}, inflight_r};
        issue_s       = 1'b0;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        count_next_s  = count_r;
        pc_next_s     = pc_r;
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        if (reset) begin
            pc_next_s     = RESET_PC;
            count_next_s  = {CNT_W{1'b0}};
            rd_ptr_next_s = {PTR_W{1'b0}};
            wr_ptr_next_s = {PTR_W{1'b0}};
        end else if (next_PC_select) begin
            // Redirect wins over any push/pop; the response in flight is discarded.
            pc_next_s     = target_PC & ALIGN_MASK;
            count_next_s  = {CNT_W{1'b0}};
            rd_ptr_next_s = {PTR_W{1'b0}};
            wr_ptr_next_s = {PTR_W{1'b0}};
        end else begin
            issue_s = (occupancy_s < DEPTH_C);
            push_s  = rsp_valid & inflight_r;
            pop_s   = inst_ready & (count_r != {CNT_W{1'b0}});
            if (issue_s) begin
                pc_next_s = pc_r + PC_STEP;
            end else begin
                pc_next_s = pc_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CNT_ONE;
                2'b01:   count_next_s = count_r - CNT_ONE;
                default: count_next_s = count_r;
            endcase
            if (push_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r            <= RESET_PC;
            count_r         <= {CNT_W{1'b0}};
            inflight_r      <= 1'b0;
            inflight_addr_r <= {ADDRESS_BITS{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            wr_ptr_r        <= {PTR_W{1'b0}};
        end else begin
            pc_r       <= pc_next_s;
            count_r    <= count_next_s;
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_addr_r <= pc_r;
            end
            rd_ptr_r   <= rd_ptr_next_s;
            wr_ptr_r   <= wr_ptr_next_s;
        end
    end

    // Queue storage: {address, word} written on each accepted response.
    always_ff @(posedge clock) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= inflight_addr_r;
            data_mem_r[wr_ptr_r] <= rsp_data;
        end
    end

    assign req_valid  = issue_s;
    assign req_addr   = pc_r;
    assign PC         = pc_r;
    assign count      = count_r;
    assign inst_valid = (count_r != {CNT_W{1'b0}});
    assign inst_data  = data_mem_r[rd_ptr_r];
    assign inst_PC    = pc_mem_r[rd_ptr_r];

endmodule
